// File: rtl/mousetrap_sync_rx.sv
// Clocked receiver for a two-phase MouseTrap pipeline: ReqIn synchroniser, FWFT FIFO, AckOut toggle.
// Optional MOUSETRAP_RX_COUNT_EN adds a 16-bit TokenCount of accepted tokens.
module mousetrap_sync_rx #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  ReqIn,
  input  logic [DATA_WIDTH-1:0] DataIn,
  output logic                  AckOut,
  output logic                  OutValid,
  output logic [DATA_WIDTH-1:0] OutData,
  input  logic                  OutReady,
  output logic                  Full
`ifdef MOUSETRAP_RX_COUNT_EN
  ,
  output logic [15:0]           TokenCount
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [SYNC_STAGES-1:0] req_sync;
  logic [AW:0]            wr_ptr;
  logic [AW:0]            rd_ptr;
  logic [DATA_WIDTH-1:0]  mem [DEPTH];
  logic                   pending;
  logic                   accept;
  logic                   pop;
  logic                   empty;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      req_sync <= '0;
    end else begin
      req_sync <= {req_sync[SYNC_STAGES-2:0], ReqIn};
    end
  end

  assign empty    = (wr_ptr == rd_ptr);
  assign Full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign OutValid = ~empty;
  assign OutData  = mem[rd_ptr[AW-1:0]];

  // DataIn is only sampled while a token is pending, when bundling keeps it stable.
  assign pending = req_sync[SYNC_STAGES-1] ^ AckOut;
  assign accept  = pending & ~Full;
  assign pop     = ~empty & OutReady;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      AckOut <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
        AckOut <= ~AckOut;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (accept) begin
      mem[wr_ptr[AW-1:0]] <= DataIn;
    end
  end

`ifdef MOUSETRAP_RX_COUNT_EN
  always_ff @(posedge Clock) begin
    if (Reset) begin
      TokenCount <= '0;
    end else if (accept) begin
      TokenCount <= TokenCount + 16'd1;
    end
  end
`endif

endmodule
